nios_sys_onchip_mem_loader: RTL and testbench

//  Upstream Avalon-MM write master for the 8192x32 on-chip RAM's second port (s2).

---
 rtl/nios_sys_onchip_mem_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_nios_sys_onchip_mem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sys_onchip_mem_loader.sv
// -----------------------------------------------------------------------------
// nios_sys_onchip_mem_loader
//
// Purpose:
//   Avalon-MM write master for the second port (s2) of the 8192x32 on-chip RAM.
//   It takes a byte stream (valid/ready) and packs bytes four at a time,
//   little-endian, into 32-bit words. The words are written at consecutive
//   addresses starting at base_addr. This lets a firmware or data image be
//   loaded at run time without the Nios core. busy/done/error go to a CSR/PIO.
//
// Optional feature (compile-time macro LOADER_VERIFY_EN):
//   When the macro is defined, each word write is followed by a read-back of
//   the same address. The enabled byte lanes are compared with the data that
//   was written, and a mismatch sets error. This costs 7 cycles per word
//   instead of 5. When the macro is undefined, no read cycles are issued and
//   i_m_readdata is ignored.
//
// Ports:
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_start               1-cycle start pulse, sampled only while idle
//   i_base_addr           first word address (captured on start)
//   i_byte_count          number of bytes to load (captured on start)
//   i_s_data/i_s_valid    byte stream in
//   o_s_ready             byte stream ready
//   o_m_*                 Avalon-MM master towards the RAM (no waitrequest)
//   i_m_readdata          RAM read data, valid one cycle after a read
//   o_m_clken             RAM clock enable, held at 1
//   o_busy / o_done       transfer in progress / 1-cycle completion pulse
//   o_error               sticky error (address wrap or verify mismatch)
//   o_words_written       words written during the current/last transfer
// -----------------------------------------------------------------------------
module nios_sys_onchip_mem_loader #(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_byte_count,
    input  logic [7:0]        i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [ADDR_W-1:0] o_m_address,
    output logic [3:0]        o_m_byteenable,
    output logic              o_m_chipselect,
    output logic              o_m_write,
    output logic [31:0]       o_m_writedata,
    input  logic [31:0]       i_m_readdata,
    output logic              o_m_clken,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CMP,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_addr;       // address of the word being assembled
    logic [CNT_W-1:0]  r_remaining;  // bytes still to be accepted
    logic [1:0]        r_lane;       // next byte lane to fill
    logic [31:0]       r_data;       // word under assembly
    logic [3:0]        r_be;         // lanes filled so far
    logic              r_at_top;     // last write went to the top address
    logic              r_error;
    logic [ADDR_W:0]   r_words;

    logic w_start_ok;
    logic w_accept;
    logic w_word_full;
    logic w_more;
    logic w_word_end;

    assign w_start_ok  = (r_state == S_IDLE) && i_start;
    assign w_accept    = (r_state == S_COLLECT) && i_s_valid;
    // A word is complete on its 4th byte or on the last byte of the transfer.
    assign w_word_full = w_accept && ((r_lane == 2'd3) || (r_remaining == CNT_W'(1)));
    assign w_more      = (r_remaining != '0);

`ifdef LOADER_VERIFY_EN
    logic [31:0] w_mask;
    logic        w_miscompare;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign w_mask[8*gi +: 8] = {8{r_be[gi]}};
        end
    endgenerate

    assign w_miscompare = (((i_m_readdata ^ r_data) & w_mask) != 32'h0);
    // With read-back, a word is finished only after its compare cycle.
    assign w_word_end   = (r_state == S_VERIFY_CMP);
`else
    logic w_unused_readdata;
    assign w_unused_readdata = ^i_m_readdata;
    assign w_word_end        = (r_state == S_WRITE);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_byte_count == '0) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_word_full) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef LOADER_VERIFY_EN
                w_state_next = S_VERIFY_RD;
`else
                w_state_next = w_more ? S_COLLECT : S_FINISH;
`endif
            end
            S_VERIFY_RD:  w_state_next = S_VERIFY_CMP;
            S_VERIFY_CMP: w_state_next = w_more ? S_COLLECT : S_FINISH;
            S_FINISH:     w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        o_s_ready      = 1'b0;
        o_m_address    = '0;
        o_m_byteenable = 4'b0000;
        o_m_chipselect = 1'b0;
        o_m_write      = 1'b0;
        o_m_writedata  = 32'h0;
        o_done         = 1'b0;
        o_busy         = (r_state != S_IDLE);
        case (r_state)
            S_COLLECT: o_s_ready = 1'b1;
            S_WRITE: begin
                o_m_chipselect = 1'b1;
                o_m_write      = 1'b1;
                o_m_address    = r_addr;
                o_m_byteenable = r_be;
                o_m_writedata  = r_data;
            end
            S_VERIFY_RD: begin
                o_m_chipselect = 1'b1;
                o_m_address    = r_addr;
                o_m_byteenable = r_be;
            end
            S_FINISH: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_m_clken       = 1'b1;
    assign o_error         = r_error;
    assign o_words_written = r_words;

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane      <= 2'd0;
            r_data      <= 32'h0;
            r_be        <= 4'b0000;
            r_at_top    <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
        end else begin
            if (w_start_ok) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_byte_count;
                r_lane      <= 2'd0;
                r_data      <= 32'h0;
                r_be        <= 4'b0000;
                r_at_top    <= 1'b0;
                r_error     <= 1'b0;
                r_words     <= '0;
            end

            if (w_accept) begin
                // Lane 0 starts a fresh word, so stale upper lanes are cleared
                // here and a partial last word carries zeros in unused lanes.
                if (r_lane == 2'd0) begin
                    r_data <= {24'h0, i_s_data};
                    r_be   <= 4'b0001;
                end else begin
                    r_data[{r_lane, 3'b000} +: 8] <= i_s_data;
                    r_be[r_lane]                  <= 1'b1;
                end
                r_lane      <= r_lane + 2'd1;
                r_remaining <= r_remaining - CNT_W'(1);
            end

            if (r_state == S_WRITE) begin
                r_words  <= r_words + (ADDR_W+1)'(1);
                // A write that follows one at the top address has wrapped.
                if (r_at_top) begin
                    r_error <= 1'b1;
                end
                r_at_top <= (r_addr == '1);
            end

            if (w_word_end) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

`ifdef LOADER_VERIFY_EN
            if ((r_state == S_VERIFY_CMP) && w_miscompare) begin
                r_error <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_nios_sys_onchip_mem_loader.sv
// -----------------------------------------------------------------------------
// Testbench for nios_sys_onchip_mem_loader.
// Directed transfers with hand-computed expected writes. A simple RAM model
// answers reads and records every write strobe.
// -----------------------------------------------------------------------------
module tb_nios_sys_onchip_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [12:0] i_base_addr = '0;
    logic [14:0] i_byte_count = '0;
    logic [7:0]  i_s_data = '0;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [12:0] o_m_address;
    logic [3:0]  o_m_byteenable;
    logic        o_m_chipselect;
    logic        o_m_write;
    logic [31:0] o_m_writedata;
    logic [31:0] rd_q = '0;
    logic        o_m_clken;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [13:0] o_words_written;

    nios_sys_onchip_mem_loader dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_byte_count   (i_byte_count),
        .i_s_data       (i_s_data),
        .i_s_valid      (i_s_valid),
        .o_s_ready      (o_s_ready),
        .o_m_address    (o_m_address),
        .o_m_byteenable (o_m_byteenable),
        .o_m_chipselect (o_m_chipselect),
        .o_m_write      (o_m_write),
        .o_m_writedata  (o_m_writedata),
        .i_m_readdata   (rd_q),
        .o_m_clken      (o_m_clken),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_words_written(o_words_written)
    );

    always #5 clk = ~clk;

    // RAM model with write log; corrupt flips bit 0 of read data.
    logic [31:0] ram [0:8191];
    logic [12:0] wr_a [$];
    logic [31:0] wr_d [$];
    logic [3:0]  wr_b [$];
    logic        corrupt = 1'b0;

    always @(posedge clk) begin
        if (o_m_chipselect && o_m_write) begin
            for (int k = 0; k < 4; k++) begin
                if (o_m_byteenable[k]) ram[o_m_address][8*k +: 8] <= o_m_writedata[8*k +: 8];
            end
            wr_a.push_back(o_m_address);
            wr_d.push_back(o_m_writedata);
            wr_b.push_back(o_m_byteenable);
        end
        rd_q <= ram[o_m_address] ^ {31'h0, corrupt};
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int done_cyc;
    int busy_n;
    int done_n;
    int w0;

    // Run one transfer: bytes b0, b0+1, ... ; toggle drops s_valid every other
    // cycle; poke issues stray start pulses while the loader is busy.
    task automatic run_xfer(input logic [12:0] base, input logic [14:0] cnt,
                            input logic [7:0] b0, input bit toggle, input bit poke);
        int idx = 0;
        int cyc;
        done_cyc = -1;
        busy_n = 0;
        done_n = 0;
        w0 = wr_a.size();
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = base;
        i_byte_count = cnt;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 300 && !(done_n > 0 && cyc >= done_cyc + 2)) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            i_s_valid = (idx < int'(cnt)) && (!toggle || (cyc % 2 == 1));
            i_s_data  = 8'(int'(b0) + idx);
            i_start   = poke && o_busy && (cyc % 3 == 0);
            i_base_addr = 13'h0AA;
            i_byte_count = 15'd3;
            if (i_s_valid && o_s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        i_s_valid = 1'b0;
        i_start = 1'b0;
        if (done_n == 0) chk("timeout_done", 32'd0, 32'd1);
        $display("xfer base=%h count=%0d writes=%0d done_cycle=%0d busy_cycles=%0d error=%0b",
                 base, cnt, wr_a.size() - w0, done_cyc, busy_n, o_error);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ready", 32'(o_s_ready), 32'd0);
        chk("rst_cs", 32'(o_m_chipselect), 32'd0);
        chk("rst_write", 32'(o_m_write), 32'd0);
        chk("rst_clken", 32'(o_m_clken), 32'd1);
        chk("rst_words", 32'(o_words_written), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1: two full words, continuous stream
        run_xfer(13'h010, 15'd8, 8'h11, 1'b0, 1'b0);
        chk("t1_nwr", 32'(wr_a.size() - w0), 32'd2);
        chk("t1_a0", 32'(wr_a[w0]), 32'h010);
        chk("t1_d0", wr_d[w0], 32'h14131211);
        chk("t1_b0", 32'(wr_b[w0]), 32'hF);
        chk("t1_a1", 32'(wr_a[w0+1]), 32'h011);
        chk("t1_d1", wr_d[w0+1], 32'h18171615);
        chk("t1_b1", 32'(wr_b[w0+1]), 32'hF);
`ifdef LOADER_VERIFY_EN
        chk("t1_done_cyc", 32'(done_cyc), 32'd15);
        chk("t1_busy_cyc", 32'(busy_n), 32'd15);
`else
        chk("t1_done_cyc", 32'(done_cyc), 32'd11);
        chk("t1_busy_cyc", 32'(busy_n), 32'd11);
`endif
        chk("t1_done_n", 32'(done_n), 32'd1);
        chk("t1_words", 32'(o_words_written), 32'd2);
        chk("t1_error", 32'(o_error), 32'd0);

        // T2: partial last word
        run_xfer(13'h100, 15'd6, 8'hA0, 1'b0, 1'b0);
        chk("t2_nwr", 32'(wr_a.size() - w0), 32'd2);
        chk("t2_a0", 32'(wr_a[w0]), 32'h100);
        chk("t2_d0", wr_d[w0], 32'hA3A2A1A0);
        chk("t2_b0", 32'(wr_b[w0]), 32'hF);
        chk("t2_a1", 32'(wr_a[w0+1]), 32'h101);
        chk("t2_d1", wr_d[w0+1], 32'h0000A5A4);
        chk("t2_b1", 32'(wr_b[w0+1]), 32'h3);
        chk("t2_words", 32'(o_words_written), 32'd2);

        // T3: zero-length transfer
        run_xfer(13'h200, 15'd0, 8'h00, 1'b0, 1'b0);
        chk("t3_nwr", 32'(wr_a.size() - w0), 32'd0);
        chk("t3_done_cyc", 32'(done_cyc), 32'd1);
        chk("t3_busy_cyc", 32'(busy_n), 32'd1);
        chk("t3_error", 32'(o_error), 32'd0);
        chk("t3_words", 32'(o_words_written), 32'd0);

        // T4: address wrap
        run_xfer(13'h1FFF, 15'd8, 8'h31, 1'b0, 1'b0);
        chk("t4_nwr", 32'(wr_a.size() - w0), 32'd2);
        chk("t4_a0", 32'(wr_a[w0]), 32'h1FFF);
        chk("t4_d0", wr_d[w0], 32'h34333231);
        chk("t4_a1", 32'(wr_a[w0+1]), 32'h0000);
        chk("t4_d1", wr_d[w0+1], 32'h38373635);
        chk("t4_error", 32'(o_error), 32'd1);
        chk("t4_done_n", 32'(done_n), 32'd1);

        // T5: gappy stream and stray starts; error cleared by the new start
        run_xfer(13'h010, 15'd8, 8'h11, 1'b1, 1'b1);
        chk("t5_nwr", 32'(wr_a.size() - w0), 32'd2);
        chk("t5_a0", 32'(wr_a[w0]), 32'h010);
        chk("t5_d0", wr_d[w0], 32'h14131211);
        chk("t5_a1", 32'(wr_a[w0+1]), 32'h011);
        chk("t5_d1", wr_d[w0+1], 32'h18171615);
        chk("t5_error", 32'(o_error), 32'd0);
        chk("t5_done_n", 32'(done_n), 32'd1);

        // T6: reset in the middle of a word
        w0 = wr_a.size();
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = 13'h020;
        i_byte_count = 15'd8;
        @(negedge clk);
        i_start = 1'b0;
        i_s_valid = 1'b1;
        i_s_data = 8'h55;
        @(negedge clk);
        i_s_data = 8'h66;
        @(negedge clk);
        i_s_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_ready", 32'(o_s_ready), 32'd0);
        chk("t6_cs", 32'(o_m_chipselect), 32'd0);
        chk("t6_clken", 32'(o_m_clken), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_nwr_rst", 32'(wr_a.size() - w0), 32'd0);
        chk("t6_words_rst", 32'(o_words_written), 32'd0);
        $display("xfer base=020 count=8 aborted by reset after 2 bytes");
        run_xfer(13'h030, 15'd8, 8'h21, 1'b0, 1'b0);
        chk("t6_nwr", 32'(wr_a.size() - w0), 32'd2);
        chk("t6_a0", 32'(wr_a[w0]), 32'h030);
        chk("t6_d0", wr_d[w0], 32'h24232221);
        chk("t6_d1", wr_d[w0+1], 32'h28272625);
        chk("t6_ram1", ram[13'h031], 32'h28272625);

`ifdef LOADER_VERIFY_EN
        // Read-back corruption must be flagged.
        corrupt = 1'b1;
        run_xfer(13'h040, 15'd4, 8'hC0, 1'b0, 1'b0);
        corrupt = 1'b0;
        chk("t6v_error", 32'(o_error), 32'd1);
        chk("t6v_done_n", 32'(done_n), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
